// File: rtl/mul_unit.sv
// Sequential shift-add multiplier (MULT/MULTU) for the EX stage.
// One partial-product iteration per clock; WIDTH iterations per multiply.
// Signed operands are reduced to magnitudes on accept, and the sign is
// reapplied to the final accumulator when the result is written.
module mul_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t             state, state_next;
  logic [WIDTH-1:0]   mcand, mplier;
  logic [2*WIDTH-1:0] acc, acc_step, acc_final;
  logic [WIDTH:0]     sum;
  logic [CW-1:0]      cnt;
  logic               neg;
  logic               accept, last;
  logic [WIDTH-1:0]   mag_a, mag_b;

  // Accept decode, operand magnitudes and one shift-add step
  always_comb begin
    accept = start && (state == IDLE || state == DONE);
    last   = (cnt == CW'(WIDTH - 1));
    mag_a  = (signed_op && op_a[WIDTH-1]) ? ('0 - op_a) : op_a;
    mag_b  = (signed_op && op_b[WIDTH-1]) ? ('0 - op_b) : op_b;
    // Carry out of the upper-half add is kept and shifted back into acc
    sum       = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (mplier[0] ? mcand : '0)};
    acc_step  = {sum, acc[WIDTH-1:1]};
    acc_final = neg ? ('0 - acc_step) : acc_step;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Datapath: operand capture, iteration and result write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else if (accept) begin
      mcand  <= mag_a;
      mplier <= mag_b;
      neg    <= signed_op & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
      acc    <= '0;
      cnt    <= '0;
    end else if (state == RUN) begin
      acc    <= acc_step;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      if (last) begin
        hi <= acc_final[2*WIDTH-1:WIDTH];
        lo <= acc_final[WIDTH-1:0];
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule
